// File: rtl/qam_rrc_defs_pkg.sv
// qam_rrc_defs: shared coefficients and arithmetic helpers for the RRC interpolator.
// Define RRC_SAT_EN to saturate narrowed outputs instead of wrapping them.
package qam_rrc_defs;
   localparam int RRC_TAPS = 11;
   localparam int RRC_COEF_W = 8;
   // h[0] in the low byte: -2,-4,3,17,32,38,32,17,3,-4,-2
   localparam logic [RRC_TAPS*RRC_COEF_W-1:0] RRC_H = {
      8'hFE, 8'hFC, 8'h03, 8'h11, 8'h20, 8'h26, 8'h20, 8'h11, 8'h03, 8'hFC, 8'hFE};

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic signed [63:0] narrow(input logic signed [63:0] v, input int w);
`ifdef RRC_SAT_EN
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (v > hi) ? hi : (v < lo) ? lo : v;
`else
      return (v <<< (64 - w)) >>> (64 - w);
`endif
   endfunction
endpackage

// File: rtl/qam_rrc_mac.sv
// qam_rrc_mac: combinational polyphase dot product of one channel's symbol delay line.
module qam_rrc_mac #(
   parameter int DIN_W = 4,
   parameter int COEF_W = 8,
   parameter int TAPS = 11,
   parameter int SPS = 4,
   parameter int NSYM = 3,
   parameter int ACC_W = 15,
   parameter int PH_W = 2
) (
   input logic [NSYM-1:0][DIN_W-1:0] sym,
   input logic [PH_W-1:0] phase,
   input logic [TAPS*COEF_W-1:0] coef,
   output logic signed [ACC_W-1:0] acc
);
   int t;
   always_comb begin
      acc = '0;
      t = 0;
      for (int k = 0; k < NSYM; k++) begin
         t = int'(phase) + k * SPS;
         if (t < TAPS) acc = acc + ACC_W'($signed(coef[t*COEF_W +: COEF_W]) * $signed(sym[k]));
      end
   end
endmodule

// File: rtl/qam_rrc_interp.sv
// qam_rrc_interp: dual-channel polyphase RRC interpolator, SPS samples per accepted I/Q symbol.
// Define RRC_SAT_EN to saturate outputs instead of wrapping to DOUT_W bits.
module qam_rrc_interp
   import qam_rrc_defs::*;
#(
   parameter int DIN_W = 4,
   parameter int DOUT_W = 16,
   parameter int COEF_W = RRC_COEF_W,
   parameter int TAPS = RRC_TAPS,
   parameter int SPS = 4,
   parameter int SHIFT = 0,
   parameter logic [TAPS*COEF_W-1:0] H = RRC_H
) (
   input logic clk,
   input logic rst,
   input logic in_valid,
   output logic in_ready,
   input logic signed [DIN_W-1:0] in_i,
   input logic signed [DIN_W-1:0] in_q,
   output logic out_valid,
   input logic out_ready,
   output logic signed [DOUT_W-1:0] out_i,
   output logic signed [DOUT_W-1:0] out_q
);
   localparam int NSYM = (TAPS + SPS - 1) / SPS;
   localparam int ACC_W = DIN_W + COEF_W + clog2(NSYM) + 1;
   localparam int PH_W = (SPS > 1) ? clog2(SPS) : 1;
   logic [PH_W-1:0] phase;
   logic [NSYM-1:0][DIN_W-1:0] di, dq, ni, nq;
   logic signed [ACC_W-1:0] acc_i, acc_q;
   logic adv, accept;
   assign adv = !out_valid || out_ready;
   assign in_ready = adv && (phase == '0);
   assign accept = in_valid && in_ready;
   // the accept cycle filters the line with the new symbol already in slot 0
   assign ni = accept ? (NSYM*DIN_W)'({di, in_i}) : di;
   assign nq = accept ? (NSYM*DIN_W)'({dq, in_q}) : dq;
   qam_rrc_mac #(.DIN_W(DIN_W), .COEF_W(COEF_W), .TAPS(TAPS), .SPS(SPS), .NSYM(NSYM), .ACC_W(ACC_W), .PH_W(PH_W))
      u_mac_i (.sym(ni), .phase(phase), .coef(H), .acc(acc_i));
   qam_rrc_mac #(.DIN_W(DIN_W), .COEF_W(COEF_W), .TAPS(TAPS), .SPS(SPS), .NSYM(NSYM), .ACC_W(ACC_W), .PH_W(PH_W))
      u_mac_q (.sym(nq), .phase(phase), .coef(H), .acc(acc_q));
   function automatic logic signed [DOUT_W-1:0] fit(input logic signed [ACC_W-1:0] a);
      logic signed [63:0] n;
      n = narrow(64'(a >>> SHIFT), DOUT_W);
      return n[DOUT_W-1:0];
   endfunction
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
         di <= '0;
         dq <= '0;
         out_valid <= 1'b0;
         out_i <= '0;
         out_q <= '0;
      end else if (adv) begin
         di <= ni;
         dq <= nq;
         if (phase != '0 || in_valid) begin
            out_valid <= 1'b1;
            out_i <= fit(acc_i);
            out_q <= fit(acc_q);
            phase <= (phase == PH_W'(SPS - 1)) ? '0 : phase + 1'b1;
         end else out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_qam_rrc_interp.sv
// tb_qam_rrc_interp: directed checks of impulse, DC, saturation, stall, bubble and reset behaviour.
module tb_qam_rrc_interp;
   logic clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic signed [3:0] in_i, in_q;
   logic signed [15:0] out_i, out_q;
   logic s_in_ready, s_out_valid;
   logic signed [3:0] s_in_i, s_in_q;
   logic signed [7:0] s_out_i, s_out_q;
   int checks = 0;
   int failures = 0;
   int imp [12] = '{-2, -4, 3, 17, 32, 38, 32, 17, 3, -4, -2, 0};
   int dc [4] = '{33, 30, 33, 34};
`ifdef RRC_SAT_EN
   int sat_exp [4] = '{127, 127, 127, 127};
`else
   int sat_exp [4] = '{-25, -46, -25, -18};
`endif

   qam_rrc_interp u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q));

   qam_rrc_interp #(.DOUT_W(8)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_i(s_in_i), .in_q(s_in_q),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_i(s_out_i), .out_q(s_out_q));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic v, input logic signed [3:0] i, input logic signed [3:0] q);
      in_valid = v;
      in_i = i;
      in_q = q;
      step();
   endtask

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic impulse(input string tag);
      for (int c = 0; c < 12; c++) begin
         cyc(c % 4 == 0, (c == 0) ? 4'sd1 : 4'sd0, (c == 0) ? -4'sd1 : 4'sd0);
         chk({tag, "_valid"}, out_valid, 1);
         chk({tag, "_i"}, out_i, imp[c]);
         chk({tag, "_q"}, out_q, -imp[c]);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_i = '0;
      in_q = '0;
      out_ready = 1'b1;
      s_in_i = 4'sd7;
      s_in_q = 4'sd0;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_i", out_i, 0);
      chk("rst_q", out_q, 0);
      chk("rst_ready", in_ready, 1);
      chk("sat_rst_ready", s_in_ready, 1);
      impulse("imp");
      for (int c = 0; c < 16; c++) begin
         cyc(c % 4 == 0, 4'sd1, 4'sd0);
         if (c >= 8) begin
            chk("dc_i", out_i, dc[c % 4]);
            chk("dc_q", out_q, 0);
            chk("sat_i", s_out_i, sat_exp[c % 4]);
         end
      end
      cyc(1'b1, 4'sd1, 4'sd0);
      chk("bp_p0", out_i, 33);
      cyc(1'b0, 4'sd1, 4'sd0);
      chk("bp_p1", out_i, 30);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cyc(1'b1, 4'sd0, 4'sd0);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_i", out_i, 30);
         chk("bp_hold_q", out_q, 0);
         chk("bp_hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      cyc(1'b0, 4'sd1, 4'sd0);
      chk("bp_p2", out_i, 33);
      cyc(1'b0, 4'sd1, 4'sd0);
      chk("bp_p3", out_i, 34);
      out_ready = 1'b0;
      cyc(1'b1, 4'sd0, 4'sd0);
      chk("bp0_ready", in_ready, 0);
      chk("bp0_hold_i", out_i, 34);
      out_ready = 1'b1;
      cyc(1'b0, 4'sd1, 4'sd0);
      chk("bub1_valid", out_valid, 0);
      cyc(1'b0, 4'sd1, 4'sd0);
      chk("bub2_valid", out_valid, 0);
      chk("bub_ready", in_ready, 1);
      cyc(1'b1, 4'sd1, 4'sd0);
      chk("bub_resume_valid", out_valid, 1);
      chk("bub_resume_i", out_i, 33);
      cyc(1'b0, 4'sd1, 4'sd0);
      chk("bub_p1", out_i, 30);
      rst = 1'b1;
      cyc(1'b0, 4'sd0, 4'sd0);
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_i", out_i, 0);
      impulse("imp2");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
